rd_status_ctrl: RTL

Byte-stage read controller for the I2C master: the receive-direction counterpart of the write-stage controller. While `exec_rd` is held it issues one `CMD_RD` bit command per data bit to the bit-level transaction tap, collects each sampled SDA bit returned by the tap, and streams the bits MSB-first into a 1-bit read pipe. After every 8 bits it sends the master ACK, or NACK on the final byte, then repeats for `exec_rd_len` bytes and pulses `exec_rd_finish`.

---
 rtl/parameter_package.sv | 26 ++
 rtl/rd_bit_shifter.sv | 44 ++++
 rtl/rd_status_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/parameter_package.sv
// Shared I2C master constants: tap command codes, counter widths and the read-stage state type.
package parameter_package;

  localparam int unsigned CMD_W      = 4;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned BYTE_CNT_W = 24;

  localparam logic [CMD_W-1:0] CMD_IDLE    = 4'd0;
  localparam logic [CMD_W-1:0] CMD_START   = 4'd1;
  localparam logic [CMD_W-1:0] CMD_STOP    = 4'd2;
  localparam logic [CMD_W-1:0] CMD_L0      = 4'd3;
  localparam logic [CMD_W-1:0] CMD_L1      = 4'd4;
  localparam logic [CMD_W-1:0] CMD_RD      = 4'd5;
  localparam logic [CMD_W-1:0] CMD_RESTART = 4'd6;

  typedef enum logic [2:0] {
    RIDLE      = 3'd0,
    RSET_RD    = 3'd1,
    RWAIT_BIT  = 3'd2,
    RPUSH      = 3'd3,
    RSET_ACK   = 3'd4,
    RBURST_FSH = 3'd5,
    RFSH       = 3'd6
  } rd_state_t;

endpackage

// File: rtl/rd_bit_shifter.sv
// Bit/byte position tracking for the read stage, with last-bit and last-byte decode.
module rd_bit_shifter
  import parameter_package::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  len_load,
  input  logic [BYTE_CNT_W-1:0] len,
  input  logic                  bit_inc,
  input  logic                  bit_clr,
  input  logic                  byte_inc,
  input  logic                  byte_clr,
  output logic                  last_bit_c,
  output logic                  last_byte_c
);

  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [BYTE_CNT_W-1:0] len_m1;

  // A zero length is treated as a single byte.
  always_ff @(posedge clock) begin
    if (rst) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      len_m1   <= '0;
    end else begin
      if (len_load)
        len_m1 <= (len == '0) ? '0 : len - BYTE_CNT_W'(1);
      if (bit_clr)
        bit_cnt <= '0;
      else if (bit_inc)
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      if (byte_clr)
        byte_cnt <= '0;
      else if (byte_inc)
        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
    end
  end

  assign last_bit_c  = (bit_cnt == BIT_CNT_W'(7));
  assign last_byte_c = (byte_cnt == len_m1);

endmodule

// File: rtl/rd_status_ctrl.sv
// I2C master byte-stage read controller: issues CMD_RD per bit, streams sampled bits
// MSB-first into a 1-bit pipe, and closes each byte with ACK (NACK on the last).
module rd_status_ctrl
  import parameter_package::*;
#(
  parameter int unsigned CSIZE     = 4,
  parameter logic [3:0]  MODULE_ID = 4'd0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             exec_rd,
  input  logic [23:0]      exec_rd_len,
  output logic             exec_rd_finish,
  output logic             rd_timeout,
  output logic             tras_cmd_vld,
  output logic [CSIZE-1:0] tras_cmd,
  input  logic             tras_cmd_ready,
  output logic [3:0]       tras_cmd_mid,
  output logic [1:0]       tras_cmd_proc_id,
  input  logic [3:0]       curr_mid,
  input  logic [1:0]       curr_proc_id,
  input  logic             rd_bit_vld,
  input  logic             rd_bit,
  output logic             rpipe_vld,
  output logic             rpipe_data,
  output logic             rpipe_last,
  input  logic             rpipe_ready,
  output logic             timeout_cnt_req,
  input  logic             timeout
);

  rd_state_t        state, nstate;
  logic             cmd_hs, pipe_hs, bit_match;
  logic             bit_inc, bit_clr, byte_inc, byte_clr;
  logic             last_bit_c, last_byte_c;
  logic             cmd_vld_nxt, pipe_vld_nxt, pipe_data_nxt, pipe_last_nxt;
  logic             tmo_req_nxt, fin_nxt, rd_tmo_nxt;
  logic [CSIZE-1:0] cmd_nxt;
  logic [1:0]       pid_nxt;

  assign tras_cmd_mid = MODULE_ID;
  assign cmd_hs       = tras_cmd_vld && tras_cmd_ready;
  assign pipe_hs      = rpipe_vld && rpipe_ready;
  assign bit_match    = rd_bit_vld && (curr_mid == MODULE_ID) && (curr_proc_id == tras_cmd_proc_id);

  rd_bit_shifter u_shift (
    .clock       (clock),
    .rst         (rst),
    .len_load    (state == RIDLE),
    .len         (exec_rd_len),
    .bit_inc     (bit_inc),
    .bit_clr     (bit_clr),
    .byte_inc    (byte_inc),
    .byte_clr    (byte_clr),
    .last_bit_c  (last_bit_c),
    .last_byte_c (last_byte_c)
  );

  // Next state, counter strobes, and next values of the registered outputs.
  always_comb begin
    nstate   = state;
    bit_inc  = 1'b0;
    bit_clr  = 1'b0;
    byte_inc = 1'b0;
    byte_clr = 1'b0;
    case (state)
      RIDLE:      if (exec_rd) nstate = RSET_RD;
      RSET_RD:    if (cmd_hs) nstate = RWAIT_BIT;
      RWAIT_BIT: begin
        if (bit_match)    nstate = RPUSH;
        else if (timeout) nstate = RFSH;
      end
      RPUSH: begin
        if (pipe_hs) begin
          bit_inc = 1'b1;
          nstate  = last_bit_c ? RSET_ACK : RSET_RD;
        end
      end
      RSET_ACK: begin
        if (cmd_hs) begin
          bit_clr = 1'b1;
          nstate  = RBURST_FSH;
        end
      end
      RBURST_FSH: begin
        byte_inc = 1'b1;
        nstate   = last_byte_c ? RFSH : RSET_RD;
      end
      RFSH:       nstate = RIDLE;
      default:    nstate = RIDLE;
    endcase
    if (!exec_rd) nstate = RIDLE;
    if (nstate == RIDLE) begin
      bit_clr  = 1'b1;
      byte_clr = 1'b1;
    end

    cmd_vld_nxt = (nstate == RSET_RD) || (nstate == RSET_ACK);
    cmd_nxt     = CSIZE'(CMD_IDLE);
    if (nstate == RSET_RD)  cmd_nxt = CSIZE'(CMD_RD);
    if (nstate == RSET_ACK) cmd_nxt = last_byte_c ? CSIZE'(CMD_L1) : CSIZE'(CMD_L0);
    pipe_vld_nxt  = (nstate == RPUSH);
    pipe_data_nxt = (nstate == RPUSH) ? ((state == RWAIT_BIT) ? rd_bit : rpipe_data) : 1'b0;
    pipe_last_nxt = (nstate == RPUSH) && last_bit_c && last_byte_c;
    tmo_req_nxt   = (nstate == RWAIT_BIT);
    fin_nxt       = (nstate == RFSH);
    rd_tmo_nxt    = (nstate == RFSH) && (state == RWAIT_BIT);
    pid_nxt       = (nstate == RFSH) ? tras_cmd_proc_id + 2'd1 : tras_cmd_proc_id;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state            <= RIDLE;
      tras_cmd_vld     <= 1'b0;
      tras_cmd         <= CSIZE'(CMD_IDLE);
      tras_cmd_proc_id <= 2'd0;
      rpipe_vld        <= 1'b0;
      rpipe_data       <= 1'b0;
      rpipe_last       <= 1'b0;
      timeout_cnt_req  <= 1'b0;
      exec_rd_finish   <= 1'b0;
      rd_timeout       <= 1'b0;
    end else begin
      state            <= nstate;
      tras_cmd_vld     <= cmd_vld_nxt;
      tras_cmd         <= cmd_nxt;
      tras_cmd_proc_id <= pid_nxt;
      rpipe_vld        <= pipe_vld_nxt;
      rpipe_data       <= pipe_data_nxt;
      rpipe_last       <= pipe_last_nxt;
      timeout_cnt_req  <= tmo_req_nxt;
      exec_rd_finish   <= fin_nxt;
      rd_timeout       <= rd_tmo_nxt;
    end
  end

endmodule
